uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BIT_TIME, 12'h514, clk cycles per bit minus one (9600 baud).
REQ-002 Parameter: HALF_TIME, BIT_TIME/2 (truncated), start-bit mid-point offset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 RxD  input  1  serial line, idle high, LSB first, asynchronous to clk.
REQ-006 rdrf_clr  input  1  single-cycle pulse from consumer: byte taken.
REQ-007 rx_data  output  8  last received byte, held until the next frame completes.
REQ-008 rdrf  output  1  receive data register full.
REQ-009 fe  output  1  framing error of the last frame.
REQ-010 oe  output  1  overrun, sticky.
REQ-011 pe  output  1  parity error of the last frame.

Function
REQ-012 RxD SHALL pass through a 2-flop synchronizer; the "rx" term below means the synchronized value, and rx_prev means rx one cycle earlier.
REQ-013 States SHALL be mark, start, shift, parity, stop, using a 3-bit state register, a 12-bit baud_count and a 4-bit bit_count.
REQ-014 mark: bit_count=0 and baud_count=0; go to start only on rx_prev=1 and rx=0 (falling edge); a line held low SHALL NOT retrigger.
REQ-015 start: increment baud_count; at baud_count==HALF_TIME, if rx=0 clear baud_count and go to shift; if rx=1, treat it as a glitch and return to mark with no flag change.
REQ-016 shift: increment baud_count; at baud_count==BIT_TIME, sample rx into rxbuff[7] with a right shift (LSB first), clear baud_count, and increment bit_count.
REQ-017 After the 8th sample, go to parity if it is compiled in, else to stop.
REQ-018 stop: at baud_count==BIT_TIME, sample rx, then:
  - load rx_data with rxbuff;
  - set rdrf=1;
  - set fe = ~rx;
  - go to mark.
REQ-019 Each bit period SHALL be BIT_TIME+1 cycles; a data bit is sampled 1.5 bit periods after the start-edge detection, ±1 cycle.
REQ-020 A byte SHALL be loaded even when its frame has an error; fe and pe describe that byte.
REQ-021 Completing a frame while rdrf=1 SHALL set oe=1 and overwrite rx_data.
REQ-022 rdrf_clr SHALL clear rdrf and oe on the next edge.
REQ-023 If rdrf_clr and a frame completion occur in the same cycle, completion wins: rdrf=1, oe unchanged.
REQ-024 Falling edges on rx outside mark SHALL be ignored.
REQ-025 baud_count SHALL never exceed BIT_TIME and SHALL never wrap.

Reset
REQ-026 While clr=1, all of the following SHALL hold, and clr at any point, including mid-frame, SHALL abandon the partial byte with no output update:
  - state=mark, rxbuff=0, baud_count=0, bit_count=0;
  - synchronizer flops and rx_prev=1;
  - rx_data=0, rdrf=0, fe=0, oe=0, pe=0.
REQ-027 After clr is released, the first start SHALL require a fresh falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN compiles in an even-parity bit between data and stop.
REQ-029 With UART_RX_PARITY_EN defined, the parity state SHALL sample rx at baud_count==BIT_TIME and set pe at the stop-bit load to (XOR of the 8 data bits) XOR the sampled parity bit.
REQ-030 Without UART_RX_PARITY_EN, the parity state SHALL be unreachable, pe SHALL be constant 0, and the frame SHALL be 10 bits.

Verification
REQ-031 Frame 0x55, 1301 cycles/bit, valid stop -> rx_data=8'h55, rdrf=1, fe=0, oe=0 within 10 bit periods of the start edge.
REQ-032 RxD pulsed low for 200 cycles in idle -> no rdrf, state returns to mark, all flags 0.
REQ-033 Frame 0xA3 with stop bit driven 0 -> rx_data=8'hA3, rdrf=1, fe=1; next frame 0x0F with valid stop -> fe=0.
REQ-034 Frames 0x11 then 0x22 with no rdrf_clr -> rx_data=8'h22, oe=1; rdrf_clr pulse -> rdrf=0, oe=0.
REQ-035 clr asserted during bit 4 of frame 0xFF -> all outputs 0; a following frame 0x3C -> rx_data=8'h3C, fe=0.
REQ-036 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> pe=0; 0x07 with parity bit 0 -> pe=1, rdrf=1.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status flags out; master = receiver, slave = consumer
interface uart_rx_if;
  logic RxD;
  logic rdrf_clr;
  logic [7:0] rx_data;
  logic rdrf;
  logic fe;
  logic oe;
  logic pe;
  modport master (input RxD, rdrf_clr, output rx_data, rdrf, fe, oe, pe);
  modport slave (output RxD, rdrf_clr, input rx_data, rdrf, fe, oe, pe);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN); ports clk, clr (async, active-high), u (RxD/rdrf_clr in, rx_data/rdrf/fe/oe/pe out)
module uart_rx #(
  parameter logic [11:0] BIT_TIME = 12'h514,
  parameter logic [11:0] HALF_TIME = BIT_TIME / 2
) (
  input logic clk,
  input logic clr,
  uart_rx_if.master u
);
  typedef enum logic [2:0] {MARK, START, SHIFT, PARITY, STOP} state_t;
  state_t state;
  logic s1, rx, rx_prev;
  logic [11:0] baud_count;
  logic [3:0] bit_count;
  logic [7:0] rxbuff;
  logic bit_end, done;
  assign bit_end = baud_count == BIT_TIME;
  assign done = state == STOP && bit_end;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  assign u.pe = 1'b0;
`endif
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= MARK;
      s1 <= 1'b1;
      rx <= 1'b1;
      rx_prev <= 1'b1;
      baud_count <= '0;
      bit_count <= '0;
      rxbuff <= '0;
      u.rx_data <= '0;
      u.rdrf <= 1'b0;
      u.fe <= 1'b0;
      u.oe <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      u.pe <= 1'b0;
`endif
    end else begin
      s1 <= u.RxD;
      rx <= s1;
      rx_prev <= rx;
      case (state)
        MARK: begin
          baud_count <= '0;
          bit_count <= '0;
          if (rx_prev && !rx) state <= START;
        end
        START:
          if (baud_count == HALF_TIME) begin
            baud_count <= '0;
            state <= rx ? MARK : SHIFT;
          end else baud_count <= baud_count + 12'd1;
        SHIFT:
          if (bit_end) begin
            rxbuff <= {rx, rxbuff[7:1]};
            baud_count <= '0;
            bit_count <= bit_count + 4'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_count == 4'd7) state <= PARITY;
`else
            if (bit_count == 4'd7) state <= STOP;
`endif
          end else baud_count <= baud_count + 12'd1;
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (bit_end) begin
            par_bit <= rx;
            baud_count <= '0;
            state <= STOP;
          end else baud_count <= baud_count + 12'd1;
`endif
        STOP:
          if (bit_end) begin
            u.rx_data <= rxbuff;
            u.fe <= ~rx;
`ifdef UART_RX_PARITY_EN
            u.pe <= ^rxbuff ^ par_bit;
`endif
            baud_count <= '0;
            state <= MARK;
          end else baud_count <= baud_count + 12'd1;
        default: state <= MARK;
      endcase
      // a completing frame beats a same-cycle rdrf_clr, and then leaves oe alone
      if (done) begin
        u.rdrf <= 1'b1;
        if (u.rdrf && !u.rdrf_clr) u.oe <= 1'b1;
      end else if (u.rdrf_clr) begin
        u.rdrf <= 1'b0;
        u.oe <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level model of uart_rx, checked every cycle outside completion windows
module tb_uart_rx;
  localparam int P = 48;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic clr = 1'b1;
  uart_rx_if u ();
  uart_rx #(.BIT_TIME(12'd47)) dut (.clk(clk), .clr(clr), .u(u));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [7:0] e_data;
  logic e_rdrf, e_fe, e_oe, e_pe;
  bit skip = 1'b1;
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    e_data = '0;
    e_rdrf = 1'b0;
    e_fe = 1'b0;
    e_oe = 1'b0;
    e_pe = 1'b0;
  endtask
  always @(negedge clk)
    if (!skip) begin
      chk("rx_data", u.rx_data, e_data);
      chk("rdrf", u.rdrf, e_rdrf);
      chk("fe", u.fe, e_fe);
      chk("oe", u.oe, e_oe);
      chk("pe", u.pe, e_pe);
    end
  task automatic send(input logic [7:0] d, input logic stopb, input logic parb, input int abort_at);
    logic [NB-1:0] bits;
    int mid;
`ifdef UART_RX_PARITY_EN
    bits = {stopb, parb, d, 1'b0};
`else
    bits = {stopb, d, 1'b0};
`endif
    mid = NB * P - P / 2 + 3;
    for (int c = 0; c < (NB + 1) * P; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        clr = 1'b1;
        model_reset();
      end
      if (abort_at >= 0 && c == abort_at + 3) clr = 1'b0;
      u.RxD = (abort_at >= 0 && c >= abort_at) ? 1'b1 : (c < NB * P ? bits[c / P] : 1'b1);
      if (abort_at < 0 && c == mid - 7) skip = 1'b1;
      if (abort_at < 0 && c == mid + 7) begin
        if (e_rdrf) e_oe = 1'b1;
        e_rdrf = 1'b1;
        e_data = d;
        e_fe = ~stopb;
`ifdef UART_RX_PARITY_EN
        e_pe = ^d ^ parb;
`endif
        skip = 1'b0;
      end
    end
  endtask
  task automatic clear_pulse();
    @(posedge clk);
    #1 u.rdrf_clr = 1'b1;
    @(posedge clk);
    #1 u.rdrf_clr = 1'b0;
    e_rdrf = 1'b0;
    e_oe = 1'b0;
  endtask
  initial begin
    u.RxD = 1'b1;
    u.rdrf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", u.rx_data, 8'h00);
    chk("reset_rdrf", u.rdrf, 1'b0);
    chk("reset_flags", {u.fe, u.oe, u.pe}, 3'b000);
    clr = 1'b0;
    skip = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(8'h55, 1'b1, 1'b0, -1);
    chk("f55_data", u.rx_data, 8'h55);
    chk("f55_rdrf", u.rdrf, 1'b1);
    chk("f55_fe_oe", {u.fe, u.oe}, 2'b00);
    clear_pulse();
    @(posedge clk);
    #1 u.RxD = 1'b0;
    repeat (10) @(posedge clk);
    #1 u.RxD = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("glitch_rdrf", u.rdrf, 1'b0);
    chk("glitch_flags", {u.fe, u.oe, u.pe}, 3'b000);
    send(8'hA3, 1'b0, 1'b0, -1);
    chk("fa3_data", u.rx_data, 8'hA3);
    chk("fa3_fe", u.fe, 1'b1);
    clear_pulse();
    send(8'h0F, 1'b1, 1'b0, -1);
    chk("f0f_data", u.rx_data, 8'h0F);
    chk("f0f_fe", u.fe, 1'b0);
    clear_pulse();
    send(8'h11, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 1'b0, -1);
    chk("ovr_data", u.rx_data, 8'h22);
    chk("ovr_oe", u.oe, 1'b1);
    chk("ovr_rdrf", u.rdrf, 1'b1);
    clear_pulse();
    chk("clr_rdrf", u.rdrf, 1'b0);
    chk("clr_oe", u.oe, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 4 * P + P / 2);
    chk("abort_data", u.rx_data, 8'h00);
    chk("abort_flags", {u.rdrf, u.fe, u.oe, u.pe}, 4'b0000);
    send(8'h3C, 1'b1, 1'b0, -1);
    chk("f3c_data", u.rx_data, 8'h3C);
    chk("f3c_fe", u.fe, 1'b0);
`ifdef UART_RX_PARITY_EN
    clear_pulse();
    send(8'h07, 1'b1, 1'b1, -1);
    chk("par_ok_pe", u.pe, 1'b0);
    clear_pulse();
    send(8'h07, 1'b1, 1'b0, -1);
    chk("par_bad_pe", u.pe, 1'b1);
    chk("par_bad_rdrf", u.rdrf, 1'b1);
`endif
    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
